// File: rtl/pueo_trig_pkg.sv
// Shared constants and types for the PUEO trigger-source arbiter.
// Frame length and metadata layout live here so every consumer agrees on them.
package pueo_trig_pkg;

   localparam int FRAME_LEN    = 8;
   localparam int META_W       = 8;
   localparam int META_VLD_BIT = 7;
   localparam int META_SEQ_W   = 7;
   localparam int CHAN_W       = 3;
   localparam int HOLDOFF_W    = 16;
   localparam int DROP_W       = 16;

   typedef enum logic {
      WIN_IDLE,
      WIN_HOLD
   } win_state_t;

   function automatic logic [META_W-1:0] pack_meta(input logic [META_SEQ_W-1:0] seq);
      logic [META_W-1:0] m;
      m                   = '0;
      m[META_VLD_BIT]     = 1'b1;
      m[META_SEQ_W-1:0]   = seq;
      return m;
   endfunction

endpackage

// File: rtl/pueo_trig_src_chan.sv
// One trigger source channel: edge detect, holdoff, pending flag, latched
// address and per-channel sequence counter.
module pueo_trig_src_chan
   import pueo_trig_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int SEQ_W  = 7
) (
   input  logic                 sysclk_i,
   input  logic                 sysclk_rst_i,
   input  logic                 running,
   input  logic                 trig,
   input  logic                 en,
   input  logic [ADDR_W-1:0]    cur_addr,
   input  logic [ADDR_W-1:0]    offset,
   input  logic [HOLDOFF_W-1:0] holdoff,
   input  logic                 grant_clr,
   input  logic                 seq_inc,
   output logic                 pending,
   output logic [ADDR_W-1:0]    addr,
   output logic [SEQ_W-1:0]     seq,
   output logic                 drop
);

   logic                 trig_d1;
   logic [HOLDOFF_W-1:0] holdoff_cnt;
   logic                 qual;
   logic                 accept;

   assign qual   = trig & ~trig_d1 & en & running & (holdoff_cnt == '0);
   // A grant clearing this channel in the same cycle lets a new edge set it again.
   assign accept = qual & (~pending | grant_clr);
   assign drop   = qual & pending & ~grant_clr;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
      if (sysclk_rst_i) begin
         trig_d1     <= 1'b0;
         pending     <= 1'b0;
         // NOTE: addr is a plain register, not RAM, so it is reset to keep the
         // granted output deterministic from the first grant.
         addr        <= '0;
         seq         <= '0;
         holdoff_cnt <= '0;
      end else begin
         trig_d1 <= trig;
         if (!running) begin
            pending     <= 1'b0;
            seq         <= '0;
            holdoff_cnt <= '0;
         end else begin
            if (accept) begin
               pending     <= 1'b1;
               addr        <= cur_addr - offset;
               holdoff_cnt <= holdoff;
            end else begin
               if (grant_clr) begin
                  pending <= 1'b0;
               end
               if (holdoff_cnt != '0) begin
                  holdoff_cnt <= holdoff_cnt - 1'b1;
               end
            end
            if (seq_inc) begin
               seq <= seq + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pueo_trig_src_arb.sv
// Round-robin arbiter over NCHAN trigger sources; one grant per frame, presented
// as a HOLD_LEN-clock valid window with address, channel and sequence metadata.
module pueo_trig_src_arb
   import pueo_trig_pkg::*;
#(
   parameter int NCHAN    = 4,
   parameter int ADDR_W   = 12,
   parameter int SEQ_W    = 7,
   parameter int HOLD_LEN = 4,
   parameter int CAP_DLY  = 2
) (
   input  logic                    sysclk_i,
   input  logic                    sysclk_rst_i,
   input  logic                    sysclk_phase_i,
   input  logic                    running_i,
   input  logic [ADDR_W-1:0]       cur_addr_i,
   input  logic [NCHAN-1:0]        trig_i,
   input  logic [NCHAN-1:0]        en_i,
   input  logic [NCHAN*ADDR_W-1:0] offset_i,
   input  logic [15:0]             holdoff_i,
   output logic [ADDR_W-1:0]       trig_addr_o,
   output logic [7:0]              trig_meta_o,
   output logic [2:0]              trig_chan_o,
   output logic                    trig_valid_o,
   output logic [15:0]             drop_count_o
);

   localparam int NSLOT  = 2 ** CHAN_W;
   localparam int HOLD_W = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;

   logic [NCHAN-1:0]  pending;
   logic [NCHAN-1:0]  drop;
   logic [NCHAN-1:0]  grant_clr;
   logic [NCHAN-1:0]  seq_inc;
   logic [NSLOT-1:0]  pend_all;
   logic [ADDR_W-1:0] addr [NSLOT];
   logic [SEQ_W-1:0]  seq  [NSLOT];

   generate
      for (genvar c = 0; c < NSLOT; c++) begin : g_chan
         if (c < NCHAN) begin : g_used
            pueo_trig_src_chan #(
               .ADDR_W (ADDR_W),
               .SEQ_W  (SEQ_W)
            ) u_chan (
               .sysclk_i     (sysclk_i),
               .sysclk_rst_i (sysclk_rst_i),
               .running      (running_i),
               .trig         (trig_i[c]),
               .en           (en_i[c]),
               .cur_addr     (cur_addr_i),
               .offset       (offset_i[c*ADDR_W +: ADDR_W]),
               .holdoff      (holdoff_i),
               .grant_clr    (grant_clr[c]),
               .seq_inc      (seq_inc[c]),
               .pending      (pending[c]),
               .addr         (addr[c]),
               .seq          (seq[c]),
               .drop         (drop[c])
            );
         end else begin : g_pad
            assign addr[c] = '0;
            assign seq[c]  = '0;
         end
      end
   endgenerate

   // Capture strobe: sysclk_phase_i delayed by CAP_DLY clocks.
   logic cap;
   generate
      if (CAP_DLY == 0) begin : g_nodly
         assign cap = sysclk_phase_i;
      end else begin : g_dly
         logic [CAP_DLY-1:0] phase_sr;
         always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
            if (sysclk_rst_i) begin
               phase_sr <= '0;
            end else begin
               phase_sr <= (phase_sr << 1) | CAP_DLY'(sysclk_phase_i);
            end
         end
         assign cap = phase_sr[CAP_DLY-1];
      end
   endgenerate

   logic [CHAN_W-1:0] last_grant;
   logic [CHAN_W-1:0] sel;
   logic              any_pend;

   // Walk downward so the candidate nearest last_grant+1 is written last and wins.
   always_comb begin
      int idx;
      idx      = 0;
      pend_all = '0;
      pend_all[NCHAN-1:0] = pending;
      sel      = last_grant;
      any_pend = 1'b0;
      for (int k = NCHAN; k >= 1; k--) begin
         idx = int'(last_grant) + k;
         if (idx >= NCHAN) begin
            idx = idx - NCHAN;
         end
         if (pend_all[CHAN_W'(idx)]) begin
            sel      = CHAN_W'(idx);
            any_pend = 1'b1;
         end
      end
   end

   win_state_t        state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              grant;

   // Captures landing inside a window are ignored so the window length is fixed.
   assign grant     = cap & running_i & any_pend & (state == WIN_IDLE);
   assign grant_clr = grant ? (NCHAN'(1) << sel) : '0;

   always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
      if (sysclk_rst_i) begin
         state    <= WIN_IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      seq_inc      = '0;
      case (state)
         WIN_IDLE: begin
            if (grant) begin
               state_nxt    = WIN_HOLD;
               hold_cnt_nxt = HOLD_W'(HOLD_LEN - 1);
            end
         end
         WIN_HOLD: begin
            if (hold_cnt == '0) begin
               state_nxt = WIN_IDLE;
               seq_inc   = NCHAN'(1) << trig_chan_o;
            end else begin
               hold_cnt_nxt = hold_cnt - 1'b1;
            end
         end
         default: state_nxt = WIN_IDLE;
      endcase
   end

   assign trig_valid_o = (state == WIN_HOLD);

   logic [DROP_W:0]   drop_sum;
   logic [DROP_W-1:0] drop_nxt;

   always_comb begin
      drop_sum = {1'b0, drop_count_o};
      for (int c = 0; c < NCHAN; c++) begin
         drop_sum = drop_sum + (DROP_W+1)'(drop[c]);
      end
      drop_nxt = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
      if (sysclk_rst_i) begin
         trig_addr_o  <= '0;
         trig_meta_o  <= pack_meta('0);
         trig_chan_o  <= '0;
         last_grant   <= CHAN_W'(NCHAN - 1);
         drop_count_o <= '0;
      end else begin
         drop_count_o <= drop_nxt;
         if (grant) begin
            trig_addr_o <= addr[sel];
            trig_meta_o <= pack_meta(META_SEQ_W'(seq[sel]));
            trig_chan_o <= sel;
            last_grant  <= sel;
         end
      end
   end

endmodule

// File: tb/tb_pueo_trig_src_arb.sv
// Self-checking bench for pueo_trig_src_arb: directed scenarios plus randomized
// traffic compared every clock against a behavioural model.
module tb_pueo_trig_src_arb;
   import pueo_trig_pkg::*;

   localparam int NCHAN    = 4;
   localparam int ADDR_W   = 12;
   localparam int SEQ_W    = 7;
   localparam int HOLD_LEN = 4;
   localparam int CAP_DLY  = 2;

   logic                    sysclk_i = 1'b0;
   logic                    sysclk_rst_i;
   logic                    sysclk_phase_i;
   logic                    running_i;
   logic [ADDR_W-1:0]       cur_addr_i;
   logic [NCHAN-1:0]        trig_i;
   logic [NCHAN-1:0]        en_i;
   logic [NCHAN*ADDR_W-1:0] offset_i;
   logic [15:0]             holdoff_i;
   logic [ADDR_W-1:0]       trig_addr_o;
   logic [7:0]              trig_meta_o;
   logic [2:0]              trig_chan_o;
   logic                    trig_valid_o;
   logic [15:0]             drop_count_o;

   pueo_trig_src_arb #(
      .NCHAN    (NCHAN),
      .ADDR_W   (ADDR_W),
      .SEQ_W    (SEQ_W),
      .HOLD_LEN (HOLD_LEN),
      .CAP_DLY  (CAP_DLY)
   ) dut (
      .sysclk_i       (sysclk_i),
      .sysclk_rst_i   (sysclk_rst_i),
      .sysclk_phase_i (sysclk_phase_i),
      .running_i      (running_i),
      .cur_addr_i     (cur_addr_i),
      .trig_i         (trig_i),
      .en_i           (en_i),
      .offset_i       (offset_i),
      .holdoff_i      (holdoff_i),
      .trig_addr_o    (trig_addr_o),
      .trig_meta_o    (trig_meta_o),
      .trig_chan_o    (trig_chan_o),
      .trig_valid_o   (trig_valid_o),
      .drop_count_o   (drop_count_o)
   );

   always #5 sysclk_i = ~sysclk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Behavioural model: plain integers, a delay-line queue for the capture strobe.
   bit m_ph [$];
   bit m_prev [NCHAN];
   bit m_pend [NCHAN];
   int m_hold [NCHAN];
   int m_addr [NCHAN];
   int m_seq  [NCHAN];
   int m_last, m_drops, m_win_left, m_oaddr, m_ochan, m_ometa;

   task automatic model_reset();
      m_ph.delete();
      repeat (CAP_DLY) m_ph.push_back(1'b0);
      for (int c = 0; c < NCHAN; c++) begin
         m_prev[c] = 0; m_pend[c] = 0; m_hold[c] = 0; m_addr[c] = 0; m_seq[c] = 0;
      end
      m_last = NCHAN - 1; m_drops = 0; m_win_left = 0;
      m_oaddr = 0; m_ochan = 0; m_ometa = 'h80;
   endtask

   task automatic model_step();
      bit cap, qual;
      bit loaded [NCHAN];
      int g, off;
      cap = m_ph.pop_front();
      m_ph.push_back(sysclk_phase_i);
      g = -1;
      if (cap && running_i && m_win_left == 0) begin
         for (int k = 1; k <= NCHAN; k++) begin
            if (g < 0 && m_pend[(m_last + k) % NCHAN]) g = (m_last + k) % NCHAN;
         end
      end
      if (g >= 0) begin
         m_oaddr = m_addr[g]; m_ochan = g; m_ometa = 'h80 | (m_seq[g] % 128);
         m_last = g; m_win_left = HOLD_LEN;
      end else if (m_win_left > 0) begin
         m_win_left--;
         if (m_win_left == 0) m_seq[m_ochan] = (m_seq[m_ochan] + 1) % (1 << SEQ_W);
      end
      for (int c = 0; c < NCHAN; c++) begin
         loaded[c] = 0;
         qual = trig_i[c] && !m_prev[c] && en_i[c] && running_i && m_hold[c] == 0;
         if (qual && m_pend[c] && g != c) begin
            m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
         end else if (qual) begin
            off = int'(offset_i[c*ADDR_W +: ADDR_W]);
            m_pend[c] = 1;
            m_addr[c] = (int'(cur_addr_i) - off) & ((1 << ADDR_W) - 1);
            m_hold[c] = int'(holdoff_i);
            loaded[c] = 1;
         end else if (g == c) begin
            m_pend[c] = 0;
         end
         if (!loaded[c] && m_hold[c] > 0) m_hold[c]--;
         m_prev[c] = trig_i[c];
         if (!running_i) begin
            m_pend[c] = 0; m_seq[c] = 0; m_hold[c] = 0;
         end
      end
   endtask

   // Window tracking from observed DUT outputs, used by the directed scenarios.
   int         n_win, cur_len, last_len, win_off, last_phase_cyc;
   bit         prev_v;
   logic [7:0] w_meta_q [$];
   logic [2:0] w_chan_q [$];
   logic [ADDR_W-1:0] w_addr_q [$];

   task automatic tick();
      sysclk_phase_i = (cyc % FRAME_LEN == 0);
      if (sysclk_phase_i) last_phase_cyc = cyc;
      @(posedge sysclk_i);
      model_step();
      @(negedge sysclk_i);
      cyc++;
      check("valid", 32'(trig_valid_o), 32'(m_win_left > 0));
      check("addr",  32'(trig_addr_o),  32'(m_oaddr));
      check("chan",  32'(trig_chan_o),  32'(m_ochan));
      check("meta",  32'(trig_meta_o),  32'(m_ometa));
      check("drops", 32'(drop_count_o), 32'(m_drops));
      if (trig_valid_o && !prev_v) begin
         n_win++;
         win_off = cyc - last_phase_cyc;
         cur_len = 0;
         w_meta_q.push_back(trig_meta_o);
         w_chan_q.push_back(trig_chan_o);
         w_addr_q.push_back(trig_addr_o);
      end
      if (trig_valid_o) cur_len++;
      else if (prev_v) last_len = cur_len;
      prev_v = trig_valid_o;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic align(input int ph);
      while (cyc % FRAME_LEN != ph) tick();
   endtask

   task automatic pulse(input int c);
      trig_i[c] = 1'b1;
      tick();
      trig_i[c] = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      sysclk_rst_i   = 1'b1;
      trig_i         = '0;
      running_i      = 1'b1;
      sysclk_phase_i = 1'b0;
      #1;
      check("rst_valid", 32'(trig_valid_o), 32'(0));
      check("rst_addr",  32'(trig_addr_o),  32'(0));
      check("rst_meta",  32'(trig_meta_o),  32'('h80));
      check("rst_chan",  32'(trig_chan_o),  32'(0));
      check("rst_drops", 32'(drop_count_o), 32'(0));
      @(negedge sysclk_i);
      @(negedge sysclk_i);
      model_reset();
      n_win = 0; cur_len = 0; last_len = 0; win_off = 0; prev_v = 0;
      w_meta_q.delete(); w_chan_q.delete(); w_addr_q.delete();
      sysclk_rst_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int run_low;
      bit seen;
      en_i       = '1;
      offset_i   = '0;
      holdoff_i  = '0;
      cur_addr_i = '0;
      last_phase_cyc = 0;
      do_reset();

      // Single edge on ch1: offset 5, cur_addr 100.
      cur_addr_i = 12'd100;
      offset_i[1*ADDR_W +: ADDR_W] = 12'd5;
      align(3);
      pulse(1);
      run(24);
      check("a_nwin",  32'(n_win),    32'(1));
      check("a_start", 32'(win_off),  32'(3));
      check("a_len",   32'(last_len), 32'(HOLD_LEN));
      if (n_win >= 1) begin
         check("a_addr", 32'(w_addr_q[0]), 32'(95));
         check("a_chan", 32'(w_chan_q[0]), 32'(1));
         check("a_meta", 32'(w_meta_q[0]), 32'('h80));
      end

      // Edges on ch0, ch2, ch3 in one frame: served in successive frames.
      do_reset();
      align(3);
      trig_i = 4'b1101;
      tick();
      trig_i = '0;
      run(40);
      check("b_nwin", 32'(n_win), 32'(3));
      if (n_win == 3) begin
         check("b_chan0", 32'(w_chan_q[0]), 32'(0));
         check("b_chan1", 32'(w_chan_q[1]), 32'(2));
         check("b_chan2", 32'(w_chan_q[2]), 32'(3));
      end
      check("b_drops", 32'(drop_count_o), 32'(0));

      // Two edges on ch0 before one capture.
      do_reset();
      align(3);
      pulse(0);
      pulse(0);
      run(24);
      check("c_nwin",  32'(n_win),        32'(1));
      check("c_drops", 32'(drop_count_o), 32'(1));

      // Holdoff 20: edges at t, t+10 give one event; t+25 is accepted.
      do_reset();
      holdoff_i = 16'd20;
      align(3);
      for (int k = 0; k < 60; k++) begin
         trig_i[0] = (k == 0 || k == 10 || k == 25);
         tick();
      end
      check("d_nwin",  32'(n_win),        32'(2));
      check("d_drops", 32'(drop_count_o), 32'(0));
      holdoff_i = '0;

      // Address wrap and 128-grant sequence wrap on ch0.
      do_reset();
      cur_addr_i = 12'd3;
      offset_i   = '0;
      offset_i[0 +: ADDR_W] = 12'd10;
      for (int f = 0; f < 129; f++) begin
         align(3);
         pulse(0);
      end
      run(16);
      check("e_nwin", 32'(n_win), 32'(129));
      if (w_meta_q.size() == 129) begin
         check("e_addr",    32'(w_addr_q[0]),   32'('hFF9));
         check("e_meta0",   32'(w_meta_q[0]),   32'('h80));
         check("e_meta127", 32'(w_meta_q[127]), 32'('hFF));
         check("e_meta128", 32'(w_meta_q[128]), 32'('h80));
      end

      // running_i dropped while ch1 pending: no grant, then seq restarts.
      do_reset();
      cur_addr_i = 12'd50;
      repeat (2) begin
         align(3);
         pulse(1);
      end
      run(16);
      align(3);
      pulse(1);
      running_i = 1'b0;
      tick();
      running_i = 1'b1;
      run(24);
      check("f_nwin_drop", 32'(n_win), 32'(2));
      align(3);
      pulse(1);
      run(24);
      check("f_nwin", 32'(n_win), 32'(3));
      if (n_win == 3) begin
         check("f_meta_pre",  32'(w_meta_q[1]), 32'('h81));
         check("f_meta_post", 32'(w_meta_q[2]), 32'('h80));
      end

      // Reset asserted mid-window drops valid immediately.
      align(3);
      pulse(2);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = trig_valid_o;
      end
      check("g_win_seen", 32'(seen), 32'(1));
      #2 sysclk_rst_i = 1'b1;
      #1 check("g_valid_async", 32'(trig_valid_o), 32'(0));
      do_reset();

      // Randomized traffic against the model.
      run_low = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) begin
            en_i      = ($urandom_range(0, 3) == 0) ? NCHAN'($urandom) : '1;
            holdoff_i = 16'($urandom_range(0, 12));
            for (int c = 0; c < NCHAN; c++) offset_i[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
         end
         cur_addr_i = cur_addr_i + 1'b1;
         trig_i     = trig_i ^ (NCHAN'($urandom) & NCHAN'($urandom));
         if (run_low > 0) begin
            running_i = 1'b0;
            run_low--;
         end else if ($urandom_range(0, 149) == 0) begin
            running_i = 1'b0;
            run_low   = $urandom_range(0, 4);
         end else begin
            running_i = 1'b1;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
